// File: rtl/fpcvt_pkg.sv
// Shared widths, constants, state encoding and result payload for the fixed-to-float path.
package fpcvt_pkg;

    localparam int unsigned IN_W  = 12;
    localparam int unsigned EXP_W = 3;
    localparam int unsigned SIG_W = 4;
    // |d| never exceeds 0x7FF after saturation, so the shifter only needs IN_W-1 bits.
    localparam int unsigned MAG_W = IN_W - 1;

    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(7);
    localparam logic [IN_W-1:0]  MIN_NEG = 12'h800;
    localparam logic [IN_W-1:0]  SAT_MAG = 12'h7FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Normalized result handed to the rounder.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] expo;
        logic [SIG_W-1:0] sig;
        logic             fifth;
    } res_t;

endpackage

// File: rtl/fp_magnitude.sv
// Combinational sign/magnitude split of a two's-complement sample, saturating -2048 to 2047.
module fp_magnitude
    import fpcvt_pkg::*;
(
    input  logic [IN_W-1:0]  d_i,
    output logic             sign_c_o,
    output logic [MAG_W-1:0] mag_c_o
);

    // Negation only needs the low MAG_W bits: for every negative input except MIN_NEG the result fits.
    always_comb begin
        sign_c_o = d_i[IN_W-1];
        if (d_i == MIN_NEG) begin
            mag_c_o = SAT_MAG[MAG_W-1:0];
        end else if (d_i[IN_W-1]) begin
            mag_c_o = ~d_i[MAG_W-1:0] + MAG_W'(1);
        end else begin
            mag_c_o = d_i[MAG_W-1:0];
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// Iterative normalizer: one left shift per cycle until the leading one reaches the top or the exponent hits zero.
module fp_normalizer
    import fpcvt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [SIG_W-1:0] out_sig,
    output logic             out_fifth
);

    logic             mag_sign;
    logic [MAG_W-1:0] mag;

    state_e           state_q,     state_d;
    logic             sign_q,      sign_d;
    logic [MAG_W-1:0] sh_q,        sh_d;
    logic [EXP_W-1:0] expc_q,      expc_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    res_t             res_q,       res_d;

    fp_magnitude u_mag (
        .d_i      (d),
        .sign_c_o (mag_sign),
        .mag_c_o  (mag)
    );

    // Next-state and next-output logic for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        sh_d        = sh_q;
        expc_d      = expc_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d  = mag_sign;
                    sh_d    = mag;
                    expc_d  = EXP_MAX;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sh_q[MAG_W-1] || (expc_q == '0)) begin
                    res_d.sign  = sign_q;
                    res_d.expo  = expc_q;
                    res_d.sig   = sh_q[MAG_W-1 -: SIG_W];
                    res_d.fifth = sh_q[MAG_W-1-SIG_W];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    sh_d   = {sh_q[MAG_W-2:0], 1'b0};
                    expc_d = expc_q - EXP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset abandons any sample in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            sh_q        <= '0;
            expc_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            sh_q        <= sh_d;
            expc_q      <= expc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sign  = res_q.sign;
    assign out_exp   = res_q.expo;
    assign out_sig   = res_q.sig;
    assign out_fifth = res_q.fifth;

endmodule
